// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Result is computed at start, held pending, and committed when the busy window expires.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdstart,
    input  logic [2:0]  mdop,
    input  logic        hlsel,
    input  logic        hlwrite,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hl_out
);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [CW-1:0]       cnt;
    logic [31:0]         hi, lo, res_hi, res_lo;
    logic                wr_en;

    md_op_e              op;
    logic                start, is_signed, is_div, div_zero;
    logic signed [32:0]  ma, mb, dvd, dvs, quot, rem;
    logic signed [65:0]  prod;
    logic                arith_unused;

    // 33-bit operands let one signed multiplier/divider serve both signed and
    // unsigned ops, and keep 0x80000000 / -1 from overflowing.
    always_comb begin
        op        = md_op_e'(mdop[1:0]);
        start     = mdstart && !busy && !mdop[2];
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        div_zero  = (b == '0);
        ma        = is_signed ? {a[31], a} : {1'b0, a};
        mb        = is_signed ? {b[31], b} : {1'b0, b};
        prod      = ma * mb;
        dvd       = ma;
        dvs       = div_zero ? 33'sd1 : mb;
        quot      = dvd / dvs;
        rem       = dvd % dvs;
    end

    assign arith_unused = ^{prod[65:64], quot[32], rem[32]};

    assign hl_out = hlsel ? lo : hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            wr_en  <= 1'b0;
        end else if (start) begin
            cnt  <= is_div ? DIV_LOAD : MULT_LOAD;
            busy <= 1'b1;
            if (is_div) begin
                res_hi <= rem[31:0];
                res_lo <= quot[31:0];
                wr_en  <= !div_zero;
            end else begin
                res_hi <= prod[63:32];
                res_lo <= prod[31:0];
                wr_en  <= 1'b1;
            end
        end else if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            busy <= (cnt != CW'(1));
            if (cnt == CW'(1) && wr_en) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (hlwrite) begin
            if (hlsel) lo <= a;
            else       hi <= a;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences, and random traffic against a cycle-stamped reference model.
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset, mdstart, hlsel, hlwrite;
    logic [2:0]  mdop;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hl_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .mdstart(mdstart), .mdop(mdop),
        .hlsel(hlsel), .hlwrite(hlwrite), .a(a), .b(b),
        .busy(busy), .hl_out(hl_out)
    );

    always #5 clk = ~clk;

    // Reference model: edge counter plus the edge index at which the pending op completes.
    int unsigned e = 0;
    int unsigned done_at = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_valid = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (op[1:0])
            2'b00: begin p = sx * sy; return {1'b1, p[63:32], p[31:0]}; end
            2'b01: begin p = ux * uy; return {1'b1, p[63:32], p[31:0]}; end
            2'b10: begin
                if (y == 0) return {1'b0, 64'b0};
                q = sx / sy; r = sx % sy;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {1'b0, 64'b0};
                q = ux / uy; r = ux % uy;
                return {1'b1, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Apply the current inputs across one clock edge, update the model, check outputs.
    task automatic tick();
        bit was_busy;
        logic [64:0] r;
        was_busy = (e < done_at);
        e++;
        if (reset) begin
            m_hi = '0; m_lo = '0; p_valid = 1'b0; done_at = e;
        end else if (was_busy) begin
            if (e == done_at && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (mdstart && !mdop[2]) begin
            r = ref_result(mdop, a, b);
            p_valid = r[64]; p_hi = r[63:32]; p_lo = r[31:0];
            done_at = e + (mdop[1] ? DC : MC);
        end else if (hlwrite) begin
            if (hlsel) m_lo = a;
            else       m_hi = a;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'b0, busy}, {31'b0, (e < done_at)});
        chk("hl_out", hl_out, hlsel ? m_lo : m_hi);
    endtask

    task automatic peek(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic save;
        save = hlsel;
        hlsel = 1'b0; #1; chk({name, "_hi"}, hl_out, exp_hi);
        hlsel = 1'b1; #1; chk({name, "_lo"}, hl_out, exp_lo);
        hlsel = save; #1;
    endtask

    task automatic idle();
        mdstart = 1'b0; hlwrite = 1'b0; mdop = 3'b000; a = '0; b = '0;
    endtask

    task automatic mt(input logic sel, input logic [31:0] val);
        hlwrite = 1'b1; hlsel = sel; a = val;
        tick();
        idle();
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        mdstart = 1'b1; mdop = op; a = x; b = y;
        tick();
        idle();
    endtask

    // Count busy cycles following an accepted start, bounded.
    task automatic wait_idle(input string name, input int unsigned exp_n);
        int unsigned n;
        n = 0;
        for (int g = 0; g < 64; g++) begin
            if (!busy) break;
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, exp_n);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678};
        vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        reset = 1'b1; hlsel = 1'b0; idle();
        tick(); tick();
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        peek("reset", 32'h0, 32'h0);

        // Directed vector table; divide-by-zero expects the preloaded HI/LO.
        for (int i = 0; i < 8; i++) begin
            mt(1'b0, 32'h0000_1234);
            mt(1'b1, 32'h0000_5678);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle($sformatf("vec%0d", i), vecs[i].op[1] ? DC : MC);
            peek($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // Reset two cycles into a mult: no late commit.
        mt(1'b0, 32'h1111_1111);
        start_op(3'b000, 32'd6, 32'd7);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        peek("rst_mid", 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        peek("rst_no_late", 32'h0, 32'h0);

        // mthi and a different mdstart during busy are ignored.
        start_op(3'b000, 32'd6, 32'd7);
        hlwrite = 1'b1; hlsel = 1'b0; a = 32'h0000_AAAA; tick(); idle();
        mdstart = 1'b1; mdop = 3'b011; a = 32'd100; b = 32'd3; tick(); idle();
        peek("busy_hold", 32'h0, 32'h0);
        wait_idle("ign", MC - 2);
        peek("ign", 32'h0, 32'd42);

        // Back-to-back start in the first idle cycle, then mdstart+hlwrite together.
        start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("b2b_a", MC);
        mdstart = 1'b1; mdop = 3'b010; a = 32'd20; b = 32'd6;
        hlwrite = 1'b1; hlsel = 1'b1;
        tick(); idle();
        wait_idle("b2b_b", DC);
        peek("b2b", 32'd2, 32'd3);

        // Reserved opcode: no effect.
        mdstart = 1'b1; mdop = 3'b101; a = 32'd9; b = 32'd9; tick(); idle();
        chk("reserved_busy", {31'b0, busy}, 32'd0);
        peek("reserved", 32'd2, 32'd3);

        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            int unsigned k;
            k = $urandom_range(0, 99);
            reset   = (k < 2);
            mdstart = (k >= 2 && k < 40);
            hlwrite = (k >= 30 && k < 60);
            mdop    = 3'($urandom_range(0, 7));
            hlsel   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            tick();
            reset = 1'b0;
            if ($urandom_range(0, 9) == 0) peek("rand", m_hi, m_lo);
        end
        idle();
        for (int i = 0; i < 12; i++) tick();
        peek("final", m_hi, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
